id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter REG_AW, default 5, register-index width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have inputs stall (1), flush (1) and id_valid (1): hold, bubble-insert and decode-valid.
REQ-006 SHALL have inputs id_ctrl (3), ALU op, and id_shamt (5), shift amount.
REQ-007 SHALL have inputs id_rs_val and id_rt_val (DATA_W each), register-file read data.
REQ-008 SHALL have inputs id_imm (DATA_W), the extended immediate, and id_use_imm (1), which selects immediate for B.
REQ-009 SHALL have inputs id_rs, id_rt and id_rd (REG_AW each), source and destination indices.
REQ-010 SHALL have input id_reg_wr (1), destination write enable.
REQ-011 SHALL have inputs exmem_reg_wr (1), exmem_rd (REG_AW) and exmem_result (DATA_W): EX/MEM forward source.
REQ-012 SHALL have inputs memwb_reg_wr (1), memwb_rd (REG_AW) and memwb_result (DATA_W): MEM/WB forward source.
REQ-013 SHALL have outputs ctrl (3), A (DATA_W), B (DATA_W) and shamt (5), which drive the ALU ports of the same names.
REQ-014 SHALL have outputs ex_valid (1), ex_rd (REG_AW) and ex_reg_wr (1), passed toward EX/MEM.

Function
REQ-015 SHALL capture all id_* fields on a clock edge when stall=0 and flush=0; 1-cycle latency from ID to EX outputs.
REQ-016 SHALL capture B operand = id_use_imm ? id_imm : id_rt_val at the capture edge.
REQ-017 SHALL store id_use_imm; forwarding to B applies only when the stored use_imm=0.
REQ-018 SHALL, on flush=1, clear ex_valid, ex_reg_wr, ctrl and ex_rd to 0 (bubble) at that edge; flush has priority over stall.
REQ-019 SHALL, on stall=1 with flush=0, hold ctrl, shamt, ex_rd, ex_reg_wr, ex_valid and the indices unchanged.
REQ-020 SHALL drive A combinationally as follows: exmem_result if exmem_reg_wr, exmem_rd==stored rs and rs!=0; else memwb_result if memwb_reg_wr, memwb_rd==stored rs and rs!=0; else the stored rs value.
REQ-021 SHALL drive B by the same rule against stored rt, gated by REQ-017.
REQ-022 SHALL give EX/MEM priority over MEM/WB when both match.
REQ-023 SHALL never forward for register index 0.
REQ-024 SHALL, on each stalled edge, overwrite the stored operands with the current forwarded A/B (operand refresh), so values survive producer retirement during multi-cycle stalls.
REQ-025 SHALL ignore all forwarding when ex_valid=0; A and B then show the stored values.

Reset
REQ-026 SHALL, on rst_n low and independent of clk, force all outputs and stored state to 0, including ex_valid=0 and ctrl=000.
REQ-027 SHALL resume capture on the first rising edge after rst_n deasserts; reset mid-stall discards the held instruction.

Configuration
REQ-028 SHALL compile forwarding (REQ-020..025) only when macro ID_EX_FORWARD_EN is defined.
REQ-029 SHALL, without ID_EX_FORWARD_EN, drive A and B directly from the stored operands, perform no refresh on stall, and leave the exmem_*/memwb_* ports present but unused.

Structure
REQ-030 SHALL take the ALU op encodings (3-bit ctrl constants) and DATA_W/REG_AW defaults from the shared CPU package, where the EX/MEM stage also uses them.
REQ-031 SHALL place forwarding selection in one sub-module, fwd_mux, instanced once per operand.

Verification
REQ-032 Reset: rst_n=0 mid-run -> ex_valid=0, A=B=0 and ctrl=000 immediately, without waiting for a clock edge.
REQ-033 Capture: id_ctrl=010, rs_val=12, rt_val=6, use_imm=0 -> next cycle ctrl=010, A=12, B=6.
REQ-034 Forward priority: stored rs=3, exmem_rd=3 with result 40, memwb_rd=3 with result 50 -> A=40; with exmem_reg_wr=0 -> A=50; with rs=0 -> stored value.
REQ-035 Stall refresh: stall=1 for 3 cycles while memwb forwards 77 for rt=4 in cycle 1 only -> B=77 held through cycle 3 and after release.
REQ-036 Flush vs stall: flush=1 and stall=1 together -> next cycle ex_valid=0, ex_reg_wr=0 and ctrl=000.
REQ-037 Immediate: use_imm=1, imm=0xFFFF_FFF0, exmem_rd matches rt -> B=0xFFFF_FFF0, no forwarding.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg -- shared CPU definitions.
// Holds the ALU operation encodings driven on ctrl and the default
// datapath/register-index widths. The EX/MEM stage imports the same package,
// so the encodings below must stay in step with the ALU.
package id_ex_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CTRL_W     = 3;
  localparam int SHAMT_W    = 5;

  localparam logic [CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [CTRL_W-1:0] ALU_XOR = 3'b100;
  localparam logic [CTRL_W-1:0] ALU_SLL = 3'b101;
  localparam logic [CTRL_W-1:0] ALU_SRL = 3'b110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 3'b111;

  // A bubble carries the all-zero op with ex_valid and ex_reg_wr low.
  localparam logic [CTRL_W-1:0] ALU_BUBBLE = ALU_ADD;

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if -- bundle between the decode side, the forwarding sources
// and the ID/EX pipeline register.
//   master : decode/hazard side; drives stall/flush, id_* fields and the
//            exmem_*/memwb_* forward sources, observes the EX-side outputs.
//   slave  : the ID/EX stage itself.
interface id_ex_stage_if #(
  parameter int DATA_W = id_ex_stage_pkg::DATA_W_DEF,
  parameter int REG_AW = id_ex_stage_pkg::REG_AW_DEF
) ();
  import id_ex_stage_pkg::*;

  logic                stall;
  logic                flush;
  logic                id_valid;
  logic [CTRL_W-1:0]   id_ctrl;
  logic [SHAMT_W-1:0]  id_shamt;
  logic [DATA_W-1:0]   id_rs_val;
  logic [DATA_W-1:0]   id_rt_val;
  logic [DATA_W-1:0]   id_imm;
  logic                id_use_imm;
  logic [REG_AW-1:0]   id_rs;
  logic [REG_AW-1:0]   id_rt;
  logic [REG_AW-1:0]   id_rd;
  logic                id_reg_wr;

  logic                exmem_reg_wr;
  logic [REG_AW-1:0]   exmem_rd;
  logic [DATA_W-1:0]   exmem_result;
  logic                memwb_reg_wr;
  logic [REG_AW-1:0]   memwb_rd;
  logic [DATA_W-1:0]   memwb_result;

  logic [CTRL_W-1:0]   ctrl;
  logic [DATA_W-1:0]   A;
  logic [DATA_W-1:0]   B;
  logic [SHAMT_W-1:0]  shamt;
  logic                ex_valid;
  logic [REG_AW-1:0]   ex_rd;
  logic                ex_reg_wr;

  modport master (
    output stall, flush, id_valid, id_ctrl, id_shamt, id_rs_val, id_rt_val,
           id_imm, id_use_imm, id_rs, id_rt, id_rd, id_reg_wr,
           exmem_reg_wr, exmem_rd, exmem_result,
           memwb_reg_wr, memwb_rd, memwb_result,
    input  ctrl, A, B, shamt, ex_valid, ex_rd, ex_reg_wr
  );

  modport slave (
    input  stall, flush, id_valid, id_ctrl, id_shamt, id_rs_val, id_rt_val,
           id_imm, id_use_imm, id_rs, id_rt, id_rd, id_reg_wr,
           exmem_reg_wr, exmem_rd, exmem_result,
           memwb_reg_wr, memwb_rd, memwb_result,
    output ctrl, A, B, shamt, ex_valid, ex_rd, ex_reg_wr
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux -- operand forwarding select for one ALU operand.
// Ports: en (forwarding allowed), idx (stored source index), stored (stored
// operand), exmem_*/memwb_* forward sources, val (selected operand).
// EX/MEM wins over MEM/WB; register 0 is never forwarded.
module fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              en,
  input  logic [REG_AW-1:0] idx,
  input  logic [DATA_W-1:0] stored,
  input  logic              exmem_reg_wr,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_wr,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] val
);

  always_comb begin
    val = stored;
    if (en && (idx != '0)) begin
      if (exmem_reg_wr && (exmem_rd == idx)) begin
        val = exmem_result;
      end else if (memwb_reg_wr && (memwb_rd == idx)) begin
        val = memwb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with operand forwarding.
// Ports: clk, rst_n (async, active-low), bus (id_ex_stage_if.slave) carrying
// stall/flush, the id_* decode fields, exmem_*/memwb_* forward sources and
// the EX-side outputs ctrl, A, B, shamt, ex_valid, ex_rd, ex_reg_wr.
// Build option: ID_EX_FORWARD_EN enables forwarding on A/B and the operand
// refresh on stalled edges. Without it the muxes sit in pass-through, so A/B
// are the stored operands and the forward-source ports have no effect.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input logic           clk,
  input logic           rst_n,
  id_ex_stage_if.slave  bus
);

  logic                ex_valid_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [SHAMT_W-1:0]  shamt_q;
  logic [REG_AW-1:0]   rd_q;
  logic                reg_wr_q;
  logic [REG_AW-1:0]   rs_q;
  logic [REG_AW-1:0]   rt_q;
  logic                use_imm_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;

  logic                fwd_en_a;
  logic                fwd_en_b;
  logic [DATA_W-1:0]   a_fwd;
  logic [DATA_W-1:0]   b_fwd;

`ifdef ID_EX_FORWARD_EN
  // A bubble never forwards; B also never forwards over an immediate.
  assign fwd_en_a = ex_valid_q;
  assign fwd_en_b = ex_valid_q & ~use_imm_q;
`else
  logic unused_use_imm;
  assign unused_use_imm = use_imm_q;
  assign fwd_en_a = 1'b0;
  assign fwd_en_b = 1'b0;
`endif

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .en(fwd_en_a), .idx(rs_q), .stored(a_q),
    .exmem_reg_wr(bus.exmem_reg_wr), .exmem_rd(bus.exmem_rd),
    .exmem_result(bus.exmem_result),
    .memwb_reg_wr(bus.memwb_reg_wr), .memwb_rd(bus.memwb_rd),
    .memwb_result(bus.memwb_result),
    .val(a_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .en(fwd_en_b), .idx(rt_q), .stored(b_q),
    .exmem_reg_wr(bus.exmem_reg_wr), .exmem_rd(bus.exmem_rd),
    .exmem_result(bus.exmem_result),
    .memwb_reg_wr(bus.memwb_reg_wr), .memwb_rd(bus.memwb_rd),
    .memwb_result(bus.memwb_result),
    .val(b_fwd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.flush) begin
      ex_valid_q <= 1'b0;
      ctrl_q     <= ALU_BUBBLE;
      shamt_q    <= '0;
      rd_q       <= '0;
      reg_wr_q   <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      use_imm_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
    end else if (bus.stall) begin
      // Latch the forwarded operands so they outlive the producer leaving
      // EX/MEM or MEM/WB while we are held. Pass-through when forwarding is off.
      a_q <= a_fwd;
      b_q <= b_fwd;
    end else begin
      ex_valid_q <= bus.id_valid;
      ctrl_q     <= bus.id_ctrl;
      shamt_q    <= bus.id_shamt;
      rd_q       <= bus.id_rd;
      reg_wr_q   <= bus.id_reg_wr;
      rs_q       <= bus.id_rs;
      rt_q       <= bus.id_rt;
      use_imm_q  <= bus.id_use_imm;
      a_q        <= bus.id_rs_val;
      b_q        <= bus.id_use_imm ? bus.id_imm : bus.id_rt_val;
    end
  end

  assign bus.ctrl      = ctrl_q;
  assign bus.shamt     = shamt_q;
  assign bus.ex_valid  = ex_valid_q;
  assign bus.ex_rd     = rd_q;
  assign bus.ex_reg_wr = reg_wr_q;
  assign bus.A         = a_fwd;
  assign bus.B         = b_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage -- directed and randomized checks of id_ex_stage against a
// behavioural model of the stage register. Follows ID_EX_FORWARD_EN.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();
  id_ex_stage #(.DATA_W(DW), .REG_AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the instruction currently held in EX.
  logic          m_valid, m_reg_wr, m_use_imm;
  logic [2:0]    m_ctrl;
  logic [4:0]    m_shamt;
  logic [AW-1:0] m_rd, m_rs, m_rt;
  logic [DW-1:0] m_a, m_b;

  function automatic logic [DW-1:0] pick(input logic live, input logic [AW-1:0] idx,
                                         input logic [DW-1:0] stored);
    if (FWD && live && idx != 0) begin
      if (bus.exmem_reg_wr && bus.exmem_rd == idx) return bus.exmem_result;
      if (bus.memwb_reg_wr && bus.memwb_rd == idx) return bus.memwb_result;
    end
    return stored;
  endfunction

  function automatic logic [DW-1:0] exp_a();
    return pick(m_valid, m_rs, m_a);
  endfunction

  function automatic logic [DW-1:0] exp_b();
    return pick(m_valid && !m_use_imm, m_rt, m_b);
  endfunction

  task automatic model_clear();
    m_valid = 0; m_reg_wr = 0; m_use_imm = 0; m_ctrl = 0; m_shamt = 0;
    m_rd = 0; m_rs = 0; m_rt = 0; m_a = 0; m_b = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [DW-1:0] na, nb;
    if (!rst_n || bus.flush) begin
      model_clear();
    end else if (bus.stall) begin
      na = exp_a();
      nb = exp_b();
      m_a = na;
      m_b = nb;
    end else begin
      m_valid   = bus.id_valid;
      m_ctrl    = bus.id_ctrl;
      m_shamt   = bus.id_shamt;
      m_rd      = bus.id_rd;
      m_reg_wr  = bus.id_reg_wr;
      m_rs      = bus.id_rs;
      m_rt      = bus.id_rt;
      m_use_imm = bus.id_use_imm;
      m_a       = bus.id_rs_val;
      m_b       = bus.id_use_imm ? bus.id_imm : bus.id_rt_val;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("ex_valid",  bus.ex_valid,  m_valid);
    chk("ctrl",      bus.ctrl,      m_ctrl);
    chk("shamt",     bus.shamt,     m_shamt);
    chk("ex_rd",     bus.ex_rd,     m_rd);
    chk("ex_reg_wr", bus.ex_reg_wr, m_reg_wr);
    chk("A",         bus.A,         exp_a());
    chk("B",         bus.B,         exp_b());
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cmp_all();
  endtask

  task automatic clr_fwd();
    bus.exmem_reg_wr = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_wr = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
  endtask

  task automatic set_id(input logic [2:0] c, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [DW-1:0] rsv, input logic [DW-1:0] rtv,
                        input logic ui, input logic [DW-1:0] imm);
    bus.id_valid = 1; bus.id_ctrl = c; bus.id_shamt = 5'd3;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = 5'd7; bus.id_reg_wr = 1;
    bus.id_rs_val = rsv; bus.id_rt_val = rtv; bus.id_use_imm = ui; bus.id_imm = imm;
  endtask

  task automatic randomize_inputs();
    bus.stall        = ($urandom_range(0, 9) < 3);
    bus.flush        = ($urandom_range(0, 9) < 1);
    bus.id_valid     = 1'($urandom);
    bus.id_ctrl      = 3'($urandom);
    bus.id_shamt     = 5'($urandom);
    bus.id_rs        = AW'($urandom_range(0, 3));
    bus.id_rt        = AW'($urandom_range(0, 3));
    bus.id_rd        = AW'($urandom_range(0, 3));
    bus.id_reg_wr    = 1'($urandom);
    bus.id_rs_val    = $urandom;
    bus.id_rt_val    = $urandom;
    bus.id_imm       = $urandom;
    bus.id_use_imm   = ($urandom_range(0, 9) < 3);
    bus.exmem_reg_wr = 1'($urandom);
    bus.exmem_rd     = AW'($urandom_range(0, 3));
    bus.exmem_result = $urandom;
    bus.memwb_reg_wr = 1'($urandom);
    bus.memwb_rd     = AW'($urandom_range(0, 3));
    bus.memwb_result = $urandom;
  endtask

  initial begin
    bus.stall = 0; bus.flush = 0;
    set_id(3'b000, 0, 0, 0, 0, 0, 0);
    bus.id_valid = 0; bus.id_reg_wr = 0;
    clr_fwd();

    // Reset without any clock edge.
    #1 rst_n = 0;
    #2;
    chk("rst_valid", bus.ex_valid, 1'b0);
    chk("rst_ctrl",  bus.ctrl, 3'b000);
    chk("rst_A",     bus.A, 32'd0);
    chk("rst_B",     bus.B, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Plain capture.
    set_id(ALU_AND, 5'd1, 5'd2, 32'd12, 32'd6, 0, 32'd0);
    step();
    chk("cap_ctrl",  bus.ctrl, 3'b010);
    chk("cap_A",     bus.A, 32'd12);
    chk("cap_B",     bus.B, 32'd6);
    chk("cap_valid", bus.ex_valid, 1'b1);

    // Forward priority on A.
    set_id(ALU_ADD, 5'd3, 5'd0, 32'd1, 32'd0, 0, 32'd0);
    step();
    bus.stall = 1;
    bus.exmem_reg_wr = 1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'd40;
    bus.memwb_reg_wr = 1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'd50;
    #1 chk("fwd_exmem", bus.A, FWD ? 32'd40 : 32'd1);
    bus.exmem_reg_wr = 0;
    #1 chk("fwd_memwb", bus.A, FWD ? 32'd50 : 32'd1);
    bus.stall = 0;
    set_id(ALU_ADD, 5'd0, 5'd0, 32'd9, 32'd0, 0, 32'd0);
    bus.exmem_reg_wr = 1; bus.exmem_rd = 5'd0;
    bus.memwb_reg_wr = 1; bus.memwb_rd = 5'd0;
    step();
    chk("fwd_r0", bus.A, 32'd9);
    clr_fwd();

    // Bubble in EX: forwarding must be ignored.
    set_id(ALU_ADD, 5'd3, 5'd0, 32'd11, 32'd0, 0, 32'd0);
    bus.id_valid = 0;
    step();
    bus.exmem_reg_wr = 1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'd99;
    #1 chk("fwd_invalid", bus.A, 32'd11);
    clr_fwd();

    // Stall refresh: producer visible only on the first stalled edge.
    set_id(ALU_OR, 5'd0, 5'd4, 32'd0, 32'd5, 0, 32'd0);
    step();
    bus.stall = 1;
    bus.memwb_reg_wr = 1; bus.memwb_rd = 5'd4; bus.memwb_result = 32'd77;
    step();
    bus.memwb_reg_wr = 0;
    #1 chk("refresh_c1", bus.B, FWD ? 32'd77 : 32'd5);
    step();
    chk("refresh_c2", bus.B, FWD ? 32'd77 : 32'd5);
    step();
    chk("refresh_c3", bus.B, FWD ? 32'd77 : 32'd5);
    bus.stall = 0;
    #1 chk("refresh_rel", bus.B, FWD ? 32'd77 : 32'd5);

    // Flush beats stall.
    set_id(ALU_SLT, 5'd1, 5'd1, 32'd3, 32'd3, 0, 32'd0);
    step();
    bus.flush = 1; bus.stall = 1;
    step();
    chk("flush_valid", bus.ex_valid, 1'b0);
    chk("flush_wr",    bus.ex_reg_wr, 1'b0);
    chk("flush_ctrl",  bus.ctrl, 3'b000);
    bus.flush = 0; bus.stall = 0;

    // Immediate on B is never overridden.
    set_id(ALU_ADD, 5'd0, 5'd5, 32'd0, 32'd1, 1, 32'hFFFF_FFF0);
    bus.exmem_reg_wr = 1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'd123;
    step();
    chk("imm_B", bus.B, 32'hFFFF_FFF0);

    // Randomized run with a reset dropped mid-cycle.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      if (i == 200) begin
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", bus.ex_valid, 1'b0);
        chk("mid_rst_ctrl",  bus.ctrl, 3'b000);
        chk("mid_rst_A",     bus.A, 32'd0);
        chk("mid_rst_B",     bus.B, 32'd0);
        @(negedge clk);
        cmp_all();
        rst_n = 1;
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
